// File: rtl/cla_pkg.sv
// Shared constants and occupancy encoding for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH   = 16;
  localparam int unsigned CLA_GROUP   = 4;
  localparam int unsigned CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/cla4_group.sv
// 4-bit lookahead group: internal carries from a group carry-in, plus group G*/P*.
module cla4_group
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] i_g,
  input  logic [CLA_GROUP-1:0] i_p,
  input  logic                 i_cin,
  output logic [CLA_GROUP-1:1] o_c,
  output logic                 o_gg,
  output logic                 o_pp
);

  always_comb begin
    o_c[1] = i_g[0] | (i_p[0] & i_cin);
    o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
           | (i_p[2] & i_p[1] & i_p[0] & i_cin);
    o_gg   = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
           | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    o_pp   = &i_p;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// 16-bit two-level carry-lookahead add/subtract, two register stages with
// valid/ready handshaking on both sides.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH   = CLA_WIDTH,
  parameter int unsigned GROUP   = CLA_GROUP,
  parameter bit          FLAG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if (WIDTH != CLA_WIDTH || GROUP != CLA_GROUP) begin : g_param_check
    $error("pipelined_cla_adder supports only WIDTH=16, GROUP=4");
  end

  occ_e                   w_occ;
  logic                   w_adv1;
  logic                   w_adv2;

  logic [WIDTH-1:0]       w_b_eff;
  logic [WIDTH-1:0]       w_g;
  logic [WIDTH-1:0]       w_p;
  logic                   w_c0;
  logic [CLA_NGROUPS-1:0] w_gg;
  logic [CLA_NGROUPS-1:0] w_pp;
  logic [CLA_NGROUPS*(CLA_GROUP-1)-1:0] w_unused_c;
  logic [CLA_NGROUPS-1:0] w_unused_gg;
  logic [CLA_NGROUPS-1:0] w_unused_pp;

  logic                   r_s1_valid;
  logic [WIDTH-1:0]       r_g;
  logic [WIDTH-1:0]       r_p;
  logic                   r_c0;
  logic [CLA_NGROUPS-1:0] r_gg;
  logic [CLA_NGROUPS-1:0] r_pp;

  logic [CLA_NGROUPS:0]   w_gc;
  logic [WIDTH:0]         w_c;
  logic [WIDTH-1:0]       w_sum;
  logic                   w_ovf;
  logic                   w_zero;

  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;
  logic                   r_ovf;
  logic                   r_zero;

  // Occupancy view of {s1_valid, out_valid}; "not FULL" equals !s1_valid | !out_valid.
  always_comb begin
    w_occ = OCC_EMPTY;
    if (r_s1_valid && r_out_valid) begin
      w_occ = OCC_FULL;
    end else if (r_s1_valid || r_out_valid) begin
      w_occ = OCC_ONE;
    end
  end

  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = (w_occ != OCC_FULL) || out_ready;
  assign in_ready = w_adv1;

  assign w_b_eff = (sub == OP_SUB) ? ~b : b;
  assign w_c0    = (sub == OP_ADD) ? cin : 1'b1;
  assign w_g     = a & w_b_eff;
  assign w_p     = a ^ w_b_eff;

  for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_grp
    cla4_group u_s1 (
      .i_g   (w_g[k*GROUP +: GROUP]),
      .i_p   (w_p[k*GROUP +: GROUP]),
      .i_cin (1'b0),
      .o_c   (w_unused_c[k*(GROUP-1) +: GROUP-1]),
      .o_gg  (w_gg[k]),
      .o_pp  (w_pp[k])
    );

    assign w_c[k*GROUP] = w_gc[k];

    cla4_group u_s2 (
      .i_g   (r_g[k*GROUP +: GROUP]),
      .i_p   (r_p[k*GROUP +: GROUP]),
      .i_cin (w_gc[k]),
      .o_c   (w_c[k*GROUP+1 +: GROUP-1]),
      .o_gg  (w_unused_gg[k]),
      .o_pp  (w_unused_pp[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_g        <= '0;
      r_p        <= '0;
      r_c0       <= 1'b0;
      r_gg       <= '0;
      r_pp       <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_g  <= w_g;
        r_p  <= w_p;
        r_c0 <= w_c0;
        r_gg <= w_gg;
        r_pp <= w_pp;
      end
    end
  end

  always_comb begin
    w_gc[0] = r_c0;
    w_gc[1] = r_gg[0] | (r_pp[0] & r_c0);
    w_gc[2] = r_gg[1] | (r_pp[1] & r_gg[0]) | (r_pp[1] & r_pp[0] & r_c0);
    w_gc[3] = r_gg[2] | (r_pp[2] & r_gg[1]) | (r_pp[2] & r_pp[1] & r_gg[0])
            | (r_pp[2] & r_pp[1] & r_pp[0] & r_c0);
    w_gc[4] = r_gg[3] | (r_pp[3] & r_gg[2]) | (r_pp[3] & r_pp[2] & r_gg[1])
            | (r_pp[3] & r_pp[2] & r_pp[1] & r_gg[0])
            | (r_pp[3] & r_pp[2] & r_pp[1] & r_pp[0] & r_c0);
  end

  assign w_c[WIDTH] = w_gc[CLA_NGROUPS];
  assign w_sum      = r_p ^ w_c[WIDTH-1:0];
  assign w_ovf      = FLAG_EN ? (w_c[WIDTH-1] ^ w_c[WIDTH]) : 1'b0;
  assign w_zero     = FLAG_EN ? (w_sum == '0) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed vectors with hand-computed results.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int unsigned acc_cyc;
    bit          chk_lat;
    int unsigned idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int          total;
  int          bad;
  int unsigned cyc;
  vec_t        vecs [14];
  exp_t        sb [$];

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .FLAG_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Present a vector and hold it until accepted; push its expected result on acceptance.
  task automatic send(input int unsigned idx, input bit chk_lat, input bit chk_rdy);
    int unsigned n;
    n = 0;
    @(negedge clk);
    a = vecs[idx].a;
    b = vecs[idx].b;
    sub = vecs[idx].sub;
    cin = vecs[idx].cin;
    in_valid = 1'b1;
    #1;
    if (chk_rdy) chk($sformatf("b2b_in_ready_v%0d", idx), {31'd0, in_ready}, 32'd1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk($sformatf("accept_timeout_v%0d", idx), {31'd0, in_ready}, 32'd1);
    end else begin
      sb.push_back('{sum: vecs[idx].sum, cout: vecs[idx].cout, ovf: vecs[idx].ovf,
                     zero: vecs[idx].zero, acc_cyc: cyc, chk_lat: chk_lat, idx: idx});
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  // Monitor: hold stability under stall, then pop/compare every retired beat.
  initial begin : monitor
    exp_t        e;
    logic        prev_stall;
    logic        prev_rst;
    logic [18:0] prev_out;
    prev_stall = 1'b0;
    prev_rst   = 1'b1;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !prev_rst && prev_stall)
        chk("stall_hold", {12'd0, out_valid, sum, cout, ovf, zero},
            {12'd0, 1'b1, prev_out});
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", {12'd0, 1'b1, sum, cout, ovf, zero}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result_v%0d", e.idx), {13'd0, sum, cout, ovf, zero},
              {13'd0, e.sum, e.cout, e.ovf, e.zero});
          if (e.chk_lat) chk($sformatf("latency_v%0d", e.idx), cyc - e.acc_cyc, 32'd2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_rst   = rst;
      prev_out   = {sum, cout, ovf, zero};
    end
  end

  initial begin : main
    int unsigned bp [4];
    int unsigned k;
    logic        rdy_last;
    total = 0;
    bad   = 0;
    vecs[0]  = '{16'h1234, 16'h4321, OP_ADD, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0000, OP_ADD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h8000, 16'h0001, OP_SUB, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, OP_SUB, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h1234, 16'h1234, OP_SUB, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, OP_ADD, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'h00FF, 16'h0F01, OP_ADD, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{16'hABCD, 16'h1234, OP_ADD, 1'b1, 16'hBE02, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'h0001, OP_SUB, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h7FFF, 16'hFFFF, OP_SUB, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'h4000, 16'h4000, OP_ADD, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{16'hF0F0, 16'h0F0F, OP_ADD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    bp = '{12, 13, 0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send(0, 1'b1, 1'b0); idle(3);
    send(1, 1'b1, 1'b0); idle(3);
    send(2, 1'b1, 1'b0);
    send(3, 1'b1, 1'b0);
    idle(1); drain();

    for (int i = 4; i < 12; i++) send(i, 1'b1, 1'b1);
    idle(1); drain();

    // Backpressure: out_ready low for five cycles under continuous offers.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    k = 0; rdy_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = vecs[bp[k]].a; b = vecs[bp[k]].b;
      sub = vecs[bp[k]].sub; cin = vecs[bp[k]].cin;
      in_valid = 1'b1;
      #1;
      rdy_last = in_ready;
      if (in_ready) begin
        sb.push_back('{sum: vecs[bp[k]].sum, cout: vecs[bp[k]].cout, ovf: vecs[bp[k]].ovf,
                       zero: vecs[bp[k]].zero, acc_cyc: cyc, chk_lat: 1'b0, idx: bp[k]});
        k++;
      end
    end
    chk("bp_accepts", k, 32'd2);
    chk("bp_in_ready_low", {31'd0, rdy_last}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    send(bp[2], 1'b0, 1'b0);
    send(bp[3], 1'b0, 1'b0);
    idle(1); drain();

    // Reset with both stages full and out_ready low.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    send(5, 1'b0, 1'b0);
    send(6, 1'b0, 1'b0);
    @(negedge clk);
    a = vecs[7].a; b = vecs[7].b; sub = vecs[7].sub; cin = vecs[7].cin;
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    idle(6);
    send(2, 1'b1, 1'b0);
    idle(1); drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
